les_trace_sequencer: RTL and testbench

Controller that sequences the LES encryption core for power-trace acquisition.
- Accepts a plaintext command with a repeat count over a valid/ready handshake.
- Fires the core's one-cycle start once per run, with a scope trigger framing each run.
- Captures the ciphertext after each run and checks that all runs agree.
- Returns one response per command, with an error flag for a timeout or a ciphertext mismatch.
- Sits between the host command interface and the LES core, which shares clk/clr with it.

---
 rtl/les_seq_pkg.sv | 22 ++
 rtl/les_seq_counter.sv | 27 ++
 rtl/les_trace_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_les_trace_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/les_seq_pkg.sv
// Shared types and constants for the LES trace-acquisition sequencer.
package les_seq_pkg;

  localparam int COUNT_W = 8;
  // Cycles the LES core holds busy after its start pulse.
  localparam int LES_LATENCY = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_RESP  = 3'd5
  } seq_state_t;

  // States during which the scope trigger frames a run.
  function automatic logic trig_framed(input seq_state_t st);
    return (st == ST_ARM) || (st == ST_START) || (st == ST_WAIT);
  endfunction

endpackage

// File: rtl/les_seq_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
module les_seq_counter
  import les_seq_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               dec,
  output logic               zero
);

  logic [COUNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/les_trace_sequencer.sv
// Sequences repeated LES encryptions for power-trace capture: trigger framing,
// start pulses, ciphertext consistency check and a single response per command.
module les_trace_sequencer
  import les_seq_pkg::*;
#(
  parameter int TRIG_PRE   = 2,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_plaintext,
  input  logic [7:0]  cmd_repeat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_ciphertext,
  output logic        rsp_error,
  output logic        les_start,
  output logic [31:0] les_plaintext,
  input  logic        les_busy,
  input  logic [31:0] les_cipher,
  output logic        trig_out,
  output logic        seq_idle
);

  // The shared counter is loaded with N-1 so that zero marks the last cycle.
  localparam logic [COUNT_W-1:0] ARM_LOAD  = COUNT_W'(TRIG_PRE - 1);
  localparam logic [COUNT_W-1:0] GAP_LOAD  = COUNT_W'(GAP_CYCLES - 1);
  localparam logic [COUNT_W-1:0] WAIT_LOAD = COUNT_W'(TIMEOUT - 1);

  seq_state_t         state_reg;
  seq_state_t         state_next;
  logic [31:0]        plaintext_reg;
  logic [31:0]        ref_reg;
  logic [31:0]        capture_reg;
  logic [COUNT_W-1:0] remaining_reg;
  logic               ref_valid_reg;
  logic               error_reg;
  logic               start_reg;
  logic               trig_reg;
  logic               ready_reg;

  logic               cnt_load;
  logic [COUNT_W-1:0] cnt_load_value;
  logic               cnt_dec;
  logic               cnt_zero;
  logic               accept;
  logic               capture;
  logic               timeout_hit;

  les_seq_counter u_counter (
    .clk        (clk),
    .clr        (clr),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_load       = 1'b0;
    cnt_load_value = ARM_LOAD;
    cnt_dec        = 1'b0;
    accept         = 1'b0;
    capture        = 1'b0;
    timeout_hit    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && ready_reg) begin
          accept         = 1'b1;
          cnt_load       = 1'b1;
          cnt_load_value = ARM_LOAD;
          state_next     = ST_ARM;
        end
      end
      ST_ARM: begin
        if (cnt_zero) begin
          state_next = ST_START;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_START: begin
        cnt_load       = 1'b1;
        cnt_load_value = WAIT_LOAD;
        state_next     = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion wins over timeout when both fall on the same cycle.
        if (!les_busy) begin
          capture = 1'b1;
          if (remaining_reg == '0) begin
            state_next = ST_RESP;
          end else begin
            cnt_load       = 1'b1;
            cnt_load_value = GAP_LOAD;
            state_next     = ST_GAP;
          end
        end else if (cnt_zero) begin
          timeout_hit = 1'b1;
          state_next  = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          cnt_load       = 1'b1;
          cnt_load_value = ARM_LOAD;
          state_next     = ST_ARM;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
      start_reg <= 1'b0;
      trig_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == ST_IDLE);
      start_reg <= (state_next == ST_START);
      trig_reg  <= trig_framed(state_next);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      plaintext_reg <= '0;
      remaining_reg <= '0;
      ref_reg       <= '0;
      ref_valid_reg <= 1'b0;
      capture_reg   <= '0;
      error_reg     <= 1'b0;
    end else begin
      if (accept) begin
        plaintext_reg <= cmd_plaintext;
        remaining_reg <= cmd_repeat;
        ref_valid_reg <= 1'b0;
        error_reg     <= 1'b0;
      end
      if (capture) begin
        capture_reg <= les_cipher;
        if (!ref_valid_reg) begin
          ref_reg       <= les_cipher;
          ref_valid_reg <= 1'b1;
        end else if (les_cipher != ref_reg) begin
          error_reg <= 1'b1;
        end
        if (remaining_reg != '0) begin
          remaining_reg <= remaining_reg - 1'b1;
        end
      end
      if (timeout_hit) begin
        capture_reg <= '0;
        error_reg   <= 1'b1;
      end
    end
  end

  assign cmd_ready      = ready_reg;
  assign rsp_valid      = (state_reg == ST_RESP);
  assign rsp_ciphertext = capture_reg;
  assign rsp_error      = error_reg;
  assign les_start      = start_reg;
  assign les_plaintext  = plaintext_reg;
  assign trig_out       = trig_reg;
  assign seq_idle       = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_les_trace_sequencer.sv
// Self-checking bench: behavioural LES core stub, table vectors, corner sequences, random commands.
`timescale 1ns/1ps
module tb_les_trace_sequencer;
  import les_seq_pkg::*;

  localparam int TRIG_PRE   = 2;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 16;
  localparam int PERIOD     = TRIG_PRE + 1 + LES_LATENCY + GAP_CYCLES;
  localparam logic [31:0] KEY   = 32'hDEADC0DE;
  localparam logic [31:0] CMASK = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        clr, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_error;
  logic        les_start, les_busy, trig_out, seq_idle;
  logic [31:0] cmd_plaintext, rsp_ciphertext, les_plaintext;
  logic [31:0] les_cipher = '0;
  logic [7:0]  cmd_repeat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_count = 0;
  int base_idx    = 0;
  int start_cyc [2048];
  logic trig_hist [4096];
  logic [31:0] run_cipher [256];
  logic        run_stuck  [256];
  int   core_cnt   = 0;
  int   core_idx   = 0;
  logic core_stuck = 1'b0;

  always #5 clk = ~clk;

  les_trace_sequencer #(
    .TRIG_PRE(TRIG_PRE), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_plaintext(cmd_plaintext), .cmd_repeat(cmd_repeat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ciphertext(rsp_ciphertext), .rsp_error(rsp_error),
    .les_start(les_start), .les_plaintext(les_plaintext),
    .les_busy(les_busy), .les_cipher(les_cipher),
    .trig_out(trig_out), .seq_idle(seq_idle)
  );

  // Core stub: busy from the start cycle for LES_LATENCY cycles; per-run result table.
  assign les_busy = les_start | (core_cnt != 0) | core_stuck;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      core_cnt   <= 0;
      core_stuck <= 1'b0;
      les_cipher <= '0;
    end else if (les_start) begin
      core_idx   <= start_count - base_idx;
      core_cnt   <= LES_LATENCY - 1;
      core_stuck <= run_stuck[(start_count - base_idx) % 256];
      start_cyc[start_count % 2048] <= cyc;
      start_count <= start_count + 1;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) les_cipher <= run_cipher[core_idx % 256];
    end
  end

  always @(negedge clk) trig_hist[cyc % 4096] <= trig_out;

  function automatic logic [31:0] les_model(input logic [31:0] pt);
    logic [31:0] x;
    x = pt ^ KEY;
    for (int r = 0; r < 4; r++) x = {x[24:0], x[31:25]} + (KEY ^ 32'(r));
    return x;
  endfunction

  task automatic fill_runs(input logic [31:0] pt, input int stuck_run, input int corrupt_run,
                           input logic [31:0] mask);
    for (int k = 0; k < 256; k++) begin
      run_cipher[k] = les_model(pt) ^ ((k == corrupt_run) ? mask : 32'h0);
      run_stuck[k]  = (k == stuck_run);
    end
  endtask

  // Reference: walk the runs; a stuck run aborts, otherwise compare against run 0.
  task automatic ref_outcome(input int rep, output logic [31:0] c, output logic e, output int n);
    logic [31:0] r;
    c = '0; e = 1'b0; n = 0; r = '0;
    for (int k = 0; k <= rep; k++) begin
      n = k + 1;
      if (run_stuck[k]) begin
        c = '0; e = 1'b1;
        break;
      end
      if (k == 0) r = run_cipher[k];
      else if (run_cipher[k] != r) e = 1'b1;
      c = run_cipher[k];
    end
  endtask

  function automatic int exp_latency(input int rep);
    for (int k = 0; k <= rep; k++)
      if (run_stuck[k]) return 1 + TRIG_PRE + k * PERIOD + 1 + TIMEOUT;
    return 1 + TRIG_PRE + LES_LATENCY + 1 + rep * PERIOD;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic issue_cmd(input logic [31:0] pt, input logic [7:0] rep,
                           output int t_acc, output int t_rsp);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready_before_issue", {31'b0, cmd_ready}, 32'd1);
    base_idx = start_count;
    cmd_valid = 1'b1; cmd_plaintext = pt; cmd_repeat = rep;
    t_acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 4000) begin @(negedge clk); n++; end
    t_rsp = cyc;
    check("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
    check("trig_low_in_resp", {31'b0, trig_out}, 32'd0);
  endtask

  task automatic finish_rsp(input int delay);
    for (int i = 0; i < delay; i++) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_rsp", {31'b0, seq_idle}, 32'd1);
    check("ready_after_rsp", {31'b0, cmd_ready}, 32'd1);
    check("rsp_valid_dropped", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic check_framing(input string tag, input int t_acc, input int n);
    int errs;
    int s;
    errs = 0;
    for (int k = 0; k < n; k++) begin
      s = start_cyc[(base_idx + k) % 2048];
      if (s != t_acc + 1 + TRIG_PRE + k * PERIOD) errs++;
      for (int c = s - TRIG_PRE; c < s + LES_LATENCY; c++)
        if (trig_hist[c % 4096] !== 1'b1) errs++;
      if (k < n - 1)
        for (int c = s + LES_LATENCY + 1; c <= s + LES_LATENCY + GAP_CYCLES; c++)
          if (trig_hist[c % 4096] !== 1'b0) errs++;
    end
    check({tag, "_framing_errs"}, errs, 0);
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] pt, input logic [7:0] rep,
                               input logic [31:0] exp_c, input logic exp_e, input int exp_n,
                               input int delay);
    int ta, tr, lat;
    lat = exp_latency(int'(rep));
    issue_cmd(pt, rep, ta, tr);
    check({tag, "_latency"}, tr - ta, lat);
    check({tag, "_cipher"}, rsp_ciphertext, exp_c);
    check({tag, "_error"}, {31'b0, rsp_error}, {31'b0, exp_e});
    check({tag, "_plaintext"}, les_plaintext, pt);
    finish_rsp(delay);
    check({tag, "_starts"}, start_count - base_idx, exp_n);
    check_framing(tag, ta, exp_n);
    $display("cmd %s pt=%h rep=%0d lat=%0d cipher=%h err=%0d starts=%0d",
             tag, pt, rep, tr - ta, exp_c, exp_e, start_count - base_idx);
  endtask

  typedef struct {
    logic [31:0] pt;
    logic [7:0]  rep;
    int          stuck_run;
    int          corrupt_run;
    logic [31:0] exp_c;
    logic        exp_e;
    int          exp_n;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int ta, tr, errs, n, n0, seen;
    logic [31:0] pt, ec, mask;
    logic ee;
    int en, rep, sr, cr;

    vecs[0] = '{32'h01234567, 8'd0,   -1, -1, les_model(32'h01234567),         1'b0, 1};
    vecs[1] = '{32'h89ABCDEF, 8'd3,   -1, -1, les_model(32'h89ABCDEF),         1'b0, 4};
    vecs[2] = '{32'h13579BDF, 8'd5,    0, -1, 32'h0,                           1'b1, 1};
    vecs[3] = '{32'h2468ACE0, 8'd2,    1, -1, 32'h0,                           1'b1, 2};
    vecs[4] = '{32'hCAFEF00D, 8'd2,   -1,  2, les_model(32'hCAFEF00D) ^ CMASK, 1'b1, 3};
    vecs[5] = '{32'h0F0F0F0F, 8'd1,   -1,  0, les_model(32'h0F0F0F0F),         1'b1, 2};
    vecs[6] = '{32'hFFFFFFFF, 8'd255, -1, -1, les_model(32'hFFFFFFFF),         1'b0, 256};
    vecs[7] = '{32'h00000000, 8'd255, 255, -1, 32'h0,                          1'b1, 256};

    clr = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_plaintext = '0; cmd_repeat = '0;
    fill_runs(32'h0, -1, -1, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_les_start", {31'b0, les_start}, 32'd0);
    check("rst_trig_out", {31'b0, trig_out}, 32'd0);
    check("rst_cipher", rsp_ciphertext, 32'd0);
    check("rst_error", {31'b0, rsp_error}, 32'd0);
    check("rst_les_plaintext", les_plaintext, 32'd0);
    check("rst_seq_idle", {31'b0, seq_idle}, 32'd1);
    clr = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'b0, cmd_ready}, 32'd1);
    while (cyc < 10) @(negedge clk);

    // Single run: trigger, start and response timing relative to acceptance.
    fill_runs(32'h01234567, -1, -1, 32'h0);
    issue_cmd(32'h01234567, 8'd0, ta, tr);
    check("A_rsp_cycle", tr - ta, 8);
    check("A_cipher", rsp_ciphertext, les_model(32'h01234567));
    check("A_error", {31'b0, rsp_error}, 32'd0);
    finish_rsp(0);
    check("A_starts", start_count - base_idx, 1);
    check("A_start_cycle", start_cyc[base_idx % 2048], ta + 3);
    errs = 0;
    for (int c = ta + 1; c <= ta + 6; c++) if (trig_hist[c % 4096] !== 1'b1) errs++;
    if (trig_hist[ta % 4096] !== 1'b0) errs++;
    if (trig_hist[tr % 4096] !== 1'b0) errs++;
    check("A_trig_window_errs", errs, 0);
    $display("cmd A pt=01234567 rep=0 lat=%0d", tr - ta);

    for (int i = 0; i < 8; i++) begin
      fill_runs(vecs[i].pt, vecs[i].stuck_run, vecs[i].corrupt_run, CMASK);
      run_and_check($sformatf("vec%0d", i), vecs[i].pt, vecs[i].rep,
                    vecs[i].exp_c, vecs[i].exp_e, vecs[i].exp_n, i % 3);
    end

    // Mismatch between run 0 and run 1.
    fill_runs(32'h11112222, -1, -1, 32'h0);
    run_cipher[0] = 32'hAAAA5555;
    run_cipher[1] = 32'hAAAA5554;
    run_and_check("D_mismatch", 32'h11112222, 8'd1, 32'hAAAA5554, 1'b1, 2, 1);

    // Response backpressure with a competing command.
    pt = 32'h3C3CA5A5;
    fill_runs(pt, -1, -1, 32'h0);
    issue_cmd(pt, 8'd1, ta, tr);
    check("E_cipher", rsp_ciphertext, les_model(pt));
    n0 = start_count;
    cmd_valid = 1'b1; cmd_plaintext = 32'h55555555; cmd_repeat = 8'd4;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_ciphertext !== les_model(pt) || rsp_error !== 1'b0 ||
          cmd_ready !== 1'b0 || les_plaintext !== pt) errs++;
    end
    check("E_hold_errs", errs, 0);
    cmd_valid = 1'b0;
    finish_rsp(0);
    check("E_no_new_start", start_count - n0, 0);
    $display("cmd E pt=%h held=20", pt);

    // Reset in the middle of WAIT.
    fill_runs(32'h0BADBEEF, -1, -1, 32'h0);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    base_idx = start_count;
    cmd_valid = 1'b1; cmd_plaintext = 32'h0BADBEEF; cmd_repeat = 8'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (start_count == base_idx && n < 50) begin @(negedge clk); n++; end
    check("F_started", start_count - base_idx, 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("F_les_start", {31'b0, les_start}, 32'd0);
    check("F_trig_out", {31'b0, trig_out}, 32'd0);
    check("F_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("F_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("F_cipher", rsp_ciphertext, 32'd0);
    check("F_error", {31'b0, rsp_error}, 32'd0);
    check("F_les_plaintext", les_plaintext, 32'd0);
    check("F_seq_idle", {31'b0, seq_idle}, 32'd1);
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("F_no_response", seen, 0);
    check("F_no_more_starts", start_count - base_idx, 1);
    $display("cmd F pt=0badbeef aborted by reset");
    fill_runs(32'h76543210, -1, -1, 32'h0);
    run_and_check("F_after", 32'h76543210, 8'd1, les_model(32'h76543210), 1'b0, 2, 0);

    // Random commands against the reference model.
    for (int i = 0; i < 12; i++) begin
      pt   = $urandom;
      rep  = int'($urandom_range(0, 6));
      sr   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rep)) : -1;
      cr   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rep)) : -1;
      mask = $urandom | 32'd1;
      fill_runs(pt, sr, cr, mask);
      ref_outcome(rep, ec, ee, en);
      run_and_check($sformatf("rnd%0d", i), pt, rep[7:0], ec, ee, en, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no_finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
